mux_pipeline_gather: RTL and testbench

Receive-side counterpart of the 4:1 byte-group pipeline mux. It accepts a stream of 32-bit words over a valid/ready handshake, each tagged with its slot index (the mux control value 0..3), and reassembles four consecutive slots into one 16-byte vector. The assembled vector is held in an output register until downstream consumes it. The block sits between the narrow 32-bit pipeline link and the wide 128-bit consumer (PE row / line buffer).

---
 rtl/mux_pipeline_pkg.sv | 20 ++
 rtl/mux_pipeline_slot_ctrl.sv | 79 +++++++
 rtl/mux_pipeline_gather.sv | 81 ++++++++
 tb/tb_mux_pipeline_gather.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pipeline_pkg.sv
// Shared widths and types for the 4:1 byte-group pipeline mux and its gather counterpart.
package mux_pipeline_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int NUM_WORDS  = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;
    localparam int VEC_W      = WORD_W * NUM_WORDS;
    localparam int SLOT_W     = $clog2(NUM_WORDS);

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [VEC_W-1:0]  vec_t;

    // Slot counter successor, wrapping after the last word of a vector.
    function automatic slot_t next_slot(input slot_t s);
        return (s == slot_t'(NUM_WORDS - 1)) ? slot_t'(0) : slot_t'(s + slot_t'(1));
    endfunction

endpackage

// File: rtl/mux_pipeline_slot_ctrl.sv
// Slot sequencing for the gather block: expected-slot counter, sticky sequence
// error, clear/resync, and the accept/write/load strobes for the datapath.
module mux_pipeline_slot_ctrl #(
    parameter int  NUM_WORDS = mux_pipeline_pkg::NUM_WORDS,
    localparam int SLOT_W    = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic              in_clear,
    input  logic              out_valid,
    input  logic              out_ready,
    output logic              in_ready,
    output logic [SLOT_W-1:0] exp_slot,
    output logic              err,
    output logic              asm_wr,
    output logic              load
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_WORDS - 1);

    logic [SLOT_W-1:0] exp_slot_reg;
    logic [SLOT_W-1:0] exp_slot_next;
    logic              err_reg;
    logic              err_next;
    logic              accept;
    logic              match;

    // Only the final slot can be stalled by a full output register.
    assign in_ready = !rst && !in_clear &&
                      (exp_slot_reg != LAST_SLOT || !out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign match    = (in_slot == exp_slot_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_slot_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            exp_slot_reg <= exp_slot_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        exp_slot_next = exp_slot_reg;
        err_next      = err_reg;
        if (in_clear) begin
            exp_slot_next = '0;
            err_next      = 1'b0;
        end else if (accept) begin
            if (match) begin
                exp_slot_next = (exp_slot_reg == LAST_SLOT) ? '0 : exp_slot_reg + 1'b1;
            end else begin
                // Resync: a stray slot-0 word opens a fresh assembly.
                err_next      = 1'b1;
                exp_slot_next = (in_slot == '0) ? SLOT_W'(1) : '0;
            end
        end
    end

    always_comb begin
        asm_wr = 1'b0;
        load   = 1'b0;
        if (accept) begin
            if (match) begin
                asm_wr = (in_slot != LAST_SLOT);
                load   = (in_slot == LAST_SLOT);
            end else begin
                asm_wr = (in_slot == '0);
            end
        end
    end

    assign exp_slot = exp_slot_reg;
    assign err      = err_reg;

endmodule

// File: rtl/mux_pipeline_gather.sv
// Reassembles NUM_WORDS slot-tagged words into one wide vector held until the
// downstream consumer takes it.
module mux_pipeline_gather #(
    parameter int  BYTE_W     = mux_pipeline_pkg::BYTE_W,
    parameter int  WORD_BYTES = mux_pipeline_pkg::WORD_BYTES,
    parameter int  NUM_WORDS  = mux_pipeline_pkg::NUM_WORDS,
    localparam int WORD_W     = BYTE_W * WORD_BYTES,
    localparam int VEC_W      = WORD_W * NUM_WORDS,
    localparam int SLOT_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [SLOT_W-1:0] in_slot,
    input  logic              in_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VEC_W-1:0]  out_data,
    output logic [SLOT_W-1:0] exp_slot,
    output logic              err
);

    logic             asm_wr;
    logic             load;
    logic [VEC_W-1:0] load_vec;
    logic [VEC_W-1:0] out_data_reg;
    logic             out_valid_reg;

    mux_pipeline_slot_ctrl #(
        .NUM_WORDS (NUM_WORDS)
    ) u_slot_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_slot   (in_slot),
        .in_clear  (in_clear),
        .out_valid (out_valid_reg),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .exp_slot  (exp_slot),
        .err       (err),
        .asm_wr    (asm_wr),
        .load      (load)
    );

    // Word k lands at the top-down position k; the final word bypasses straight into the vector.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_asm
            logic [WORD_W-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (asm_wr && in_slot == SLOT_W'(gi)) begin
                    word_reg <= in_data;
                end
            end

            assign load_vec[VEC_W-1-gi*WORD_W -: WORD_W] = word_reg;
        end
    endgenerate

    assign load_vec[WORD_W-1:0] = in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= load_vec;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_mux_pipeline_gather.sv
// Scenario bench for mux_pipeline_gather with a queue of expected vectors.
module tb_mux_pipeline_gather;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [1:0]   in_slot;
    logic         in_clear;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [1:0]   exp_slot;
    logic         err;

    int checks = 0;
    int errors = 0;
    logic [127:0] sb_q[$];
    logic [127:0] exp_vec;

    mux_pipeline_gather dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_slot   (in_slot),
        .in_clear  (in_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .exp_slot  (exp_slot),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [7:0] base, input int k);
        logic [7:0] b;
        b = base + 8'(4 * k);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    function automatic logic [127:0] vec_of(input logic [7:0] base);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[127 - 8*i -: 8] = base + 8'(i);
        return v;
    endfunction

    task automatic send_word(input logic [1:0] slot, input logic [31:0] data,
                             input logic exp_rdy, input string tag);
        in_valid = 1'b1;
        in_slot  = slot;
        in_data  = data;
        @(negedge clk);
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s in_ready slot %0d: got %b want %b", tag, slot, in_ready, exp_rdy);
        end else begin
            $display("send %s slot=%0d data=%08h in_ready=%b", tag, slot, data, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_vector(input logic [7:0] base, input bit push, input string tag);
        if (push) sb_q.push_back(vec_of(base));
        for (int k = 0; k < 4; k++) send_word(2'(k), word_of(base, k), 1'b1, tag);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || exp_slot !== 2'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h s=%0d e=%b want 0,0,0,0",
                     out_valid, out_data, exp_slot, err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
        end
        $display("reset done");
        @(posedge clk);
        #1;
    endtask

    task automatic test_in_order;
        out_ready = 1'b1;
        send_vector(8'h00, 1'b1, "in_order");
        @(negedge clk);
        exp_vec = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_vec || err !== 1'b0) begin
            errors++;
            $display("FAIL in_order_vec: got v=%b d=%h e=%b want v=1 d=%h e=0",
                     out_valid, out_data, err, exp_vec);
        end else begin
            $display("vector in_order %h", out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL in_order_one_cycle: got out_valid %b want 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int seen;
        int t_first;
        int t_second;
        logic [7:0] base;
        seen = 0;
        t_first = -1;
        t_second = -1;
        out_ready = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) begin
                base = (c < 4) ? 8'h10 : 8'h20;
                if (c % 4 == 3) sb_q.push_back(vec_of(base));
                in_valid = 1'b1;
                in_slot  = 2'(c % 4);
                in_data  = word_of(base, c % 4);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready cycle %0d: got %b want 1", c, in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                exp_vec = sb_q.pop_front();
                checks++;
                if (out_data !== exp_vec) begin
                    errors++;
                    $display("FAIL b2b_vec cycle %0d: got %h want %h", c, out_data, exp_vec);
                end else begin
                    $display("vector b2b cycle %0d %h", c, out_data);
                end
                if (seen == 0) t_first = c;
                else t_second = c;
                seen++;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen != 2 || t_first != 4 || t_second != 8) begin
            errors++;
            $display("FAIL b2b_timing: got %0d vectors at %0d,%0d want 2 at 4,8",
                     seen, t_first, t_second);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send_vector(8'h30, 1'b1, "bp_first");
        for (int k = 0; k < 3; k++) send_word(2'(k), word_of(8'h40, k), 1'b1, "bp_second");
        sb_q.push_back(vec_of(8'h40));
        in_valid = 1'b1;
        in_slot  = 2'd3;
        in_data  = word_of(8'h40, 3);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== sb_q[0]) begin
                errors++;
                $display("FAIL bp_stall cycle %0d: got rdy=%b v=%b d=%h want rdy=0 v=1 d=%h",
                         s, in_ready, out_valid, out_data, sb_q[0]);
            end else begin
                $display("stall cycle %0d holding %h", s, out_data);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp_vec = sb_q.pop_front();
        checks++;
        if (in_ready !== 1'b1 || out_data !== exp_vec) begin
            errors++;
            $display("FAIL bp_release: got rdy=%b d=%h want rdy=1 d=%h", in_ready, out_data, exp_vec);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        exp_vec = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_vec || exp_slot !== 2'd0) begin
            errors++;
            $display("FAIL bp_second_vec: got v=%b d=%h s=%0d want v=1 d=%h s=0",
                     out_valid, out_data, exp_slot, exp_vec);
        end else begin
            $display("vector bp_second %h", out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid %b want 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_slot_error;
        out_ready = 1'b1;
        send_word(2'd0, word_of(8'h50, 0), 1'b1, "err_seq");
        send_word(2'd1, word_of(8'h50, 1), 1'b1, "err_seq");
        send_word(2'd3, word_of(8'h50, 3), 1'b1, "err_seq");
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || exp_slot !== 2'd0) begin
            errors++;
            $display("FAIL slot_error: got e=%b v=%b s=%0d want e=1 v=0 s=0", err, out_valid, exp_slot);
        end else begin
            $display("slot error flagged");
        end
        @(posedge clk);
        #1;
        send_vector(8'hA0, 1'b1, "err_recover");
        @(negedge clk);
        exp_vec = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_vec || err !== 1'b1) begin
            errors++;
            $display("FAIL err_recover: got v=%b d=%h e=%b want v=1 d=%h e=1",
                     out_valid, out_data, err, exp_vec);
        end else begin
            $display("vector err_recover %h", out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clear;
        out_ready = 1'b1;
        send_word(2'd0, word_of(8'h55, 0), 1'b1, "clear");
        send_word(2'd1, word_of(8'h55, 1), 1'b1, "clear");
        in_clear = 1'b1;
        send_word(2'd2, word_of(8'h55, 2), 1'b0, "clear");
        in_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_slot !== 2'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: got s=%0d e=%b want s=0 e=0", exp_slot, err);
        end
        @(posedge clk);
        #1;
        send_vector(8'h60, 1'b1, "after_clear");
        @(negedge clk);
        exp_vec = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_vec) begin
            errors++;
            $display("FAIL after_clear_vec: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_vec);
        end else begin
            $display("vector after_clear %h", out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        send_vector(8'h70, 1'b0, "pending");
        for (int k = 0; k < 3; k++) send_word(2'(k), word_of(8'h80, k), 1'b1, "partial");
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || exp_slot !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_state: got v=%b d=%h s=%0d want 0,0,0", out_valid, out_data, exp_slot);
        end else begin
            $display("reset mid-assembly cleared");
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_vector(8'h90, 1'b1, "after_reset");
        @(negedge clk);
        exp_vec = sb_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_vec) begin
            errors++;
            $display("FAIL after_reset_vec: got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_vec);
        end else begin
            $display("vector after_reset %h", out_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_slot   = '0;
        in_clear  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_in_order();
        test_back_to_back();
        test_backpressure();
        test_slot_error();
        test_clear();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
